// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// the width of the optional grant statistics counters.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin select: the first set request found searching
// upward from (i_last_id + 1) mod N_REQ, wrapping around.
module rr_priority_sel #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_ID  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [W_ID-1:0]  i_last_id,
  output logic [N_REQ-1:0] o_gnt,
  output logic [W_ID-1:0]  o_win_id,
  output logic             o_valid
);

  logic [W_ID-1:0] w_idx;

  always_comb begin
    o_gnt    = '0;
    o_win_id = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = W_ID'((32'(i_last_id) + k) % N_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_win_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with
// burst locking and source tagging. Define FIFO_WR_ARBITER_STATS_EN for grant counters.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned W_ID      = $clog2(N_REQ),
  parameter int unsigned W_BURST   = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_lock,
  output logic [N_REQ-1:0]       ack,
  output logic [W_ID+WIDTH-1:0]  fifo_w_data,
  output logic                   fifo_w_en,
  input  logic                   fifo_full,
  output logic                   locked,
  output logic [W_ID-1:0]        last_id
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  input  logic [W_ID-1:0]        stat_sel,
  input  logic                   stat_clr,
  output logic [STAT_W-1:0]      stat_count
`endif
);

  arb_state_e         r_state;
  logic               r_locked;
  logic [W_ID-1:0]    r_last_id;
  logic [W_BURST-1:0] r_beat;

  logic [N_REQ-1:0]   w_rr_gnt;
  logic [W_ID-1:0]    w_rr_id;
  logic               w_rr_valid;
  logic [W_ID-1:0]    w_win_id;
  logic               w_cand;
  logic               w_accept;
  logic               w_win_lock;
  logic               w_owner_req;
  logic               w_owner_lock;
  logic [W_BURST-1:0] w_beat_nxt;

  rr_priority_sel #(
    .N_REQ (N_REQ),
    .W_ID  (W_ID)
  ) u_rr_sel (
    .i_req     (req),
    .i_last_id (r_last_id),
    .o_gnt     (w_rr_gnt),
    .o_win_id  (w_rr_id),
    .o_valid   (w_rr_valid)
  );

  // While locked only the owner (last winner) may transfer.
  always_comb begin
    w_owner_req  = req[r_last_id];
    w_owner_lock = req_lock[r_last_id];
    w_win_id     = (r_state == StLocked) ? r_last_id : w_rr_id;
    w_cand       = (r_state == StLocked) ? w_owner_req : w_rr_valid;
    w_accept     = rst_n & w_cand & ~fifo_full;
    w_win_lock   = req_lock[w_win_id];
    w_beat_nxt   = r_beat + 1'b1;
    ack          = '0;
    ack[w_win_id] = w_accept;
    fifo_w_en    = w_accept;
    fifo_w_data  = {w_win_id, req_data[int'(w_win_id)*WIDTH +: WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_locked  <= 1'b0;
      r_last_id <= W_ID'(N_REQ - 1);
      r_beat    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_last_id <= w_win_id;
            if (w_win_lock && (MAX_BURST > 1)) begin
              r_state  <= StLocked;
              r_locked <= 1'b1;
              r_beat   <= W_BURST'(1);
            end
          end
        end
        StLocked: begin
          if (w_accept) begin
            if (!w_win_lock || (w_beat_nxt == W_BURST'(MAX_BURST))) begin
              r_state  <= StIdle;
              r_locked <= 1'b0;
              r_beat   <= '0;
            end else begin
              r_beat <= w_beat_nxt;
            end
          end else if (!w_owner_req && !w_owner_lock) begin
            r_state  <= StIdle;
            r_locked <= 1'b0;
            r_beat   <= '0;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_locked <= 1'b0;
          r_beat   <= '0;
        end
      endcase
    end
  end

  assign locked  = r_locked;
  assign last_id = r_last_id;

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [STAT_W-1:0] r_stat [N_REQ];

  // A clear in the same cycle as a grant leaves that counter at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_clr) begin
          r_stat[i] <= ack[i] ? STAT_W'(1) : '0;
        end else if (ack[i] && (r_stat[i] != '1)) begin
          r_stat[i] <= r_stat[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stat_count = '0;
    if (32'(stat_sel) < N_REQ) stat_count = r_stat[stat_sel];
  end
`endif

endmodule
